// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational alu between two requesters.
// Operands are captured on grant; the registered result is returned tagged with the requester id.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [2:0]       f0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [2:0]       f1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done,
  output logic             rsp_id,
  output logic [WIDTH-1:0] y,
  output logic             err,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             ptr;
  logic             id;
  logic [2:0]       op_f;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             winner_c;
  logic             start_c;
  logic [WIDTH-1:0] alu_y_c;
  logic             alu_z_c;

  // Only a contended request consults the pointer; a lone request always wins.
  always_comb begin
    winner_c = req1;
    if (req0 && req1) winner_c = ptr;
    start_c = (state == IDLE) && (req0 || req1);
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0 || req1) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shared alu, fed only from the captured operands
  always_comb begin
    alu_y_c = '0;
    alu_z_c = 1'b0;
    case (op_f)
      3'd0:    alu_y_c = op_a + op_b;
      3'd1:    alu_y_c = op_a - op_b;
      3'd2:    alu_y_c = op_a & op_b;
      3'd3:    alu_y_c = op_a | op_b;
      3'd4:    alu_y_c = op_a ^ op_b;
      default: alu_z_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 1'b0;
      id     <= 1'b0;
      op_f   <= 3'd0;
      op_a   <= '0;
      op_b   <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done   <= 1'b0;
      rsp_id <= 1'b0;
      y      <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      gnt0 <= start_c && !winner_c;
      gnt1 <= start_c && winner_c;
      done <= (state == EXEC);
      busy <= (state_next != IDLE);
      if (start_c) begin
        id   <= winner_c;
        ptr  <= ~winner_c;
        op_f <= winner_c ? f1 : f0;
        op_a <= winner_c ? a1 : a0;
        op_b <= winner_c ? b1 : b0;
      end
      if (state == EXEC) begin
        y      <= alu_y_c;
        err    <= alu_z_c;
        rsp_id <= id;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: latency, round-robin alternation, invalid opcodes,
// wraparound, operand capture and reset during execution.
module tb_alu_arbiter;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [2:0]       f0, f1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1, done, rsp_id, err, busy;
  logic [WIDTH-1:0] y;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .f0(f0), .a0(a0), .b0(b0),
    .req1(req1), .f1(f1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done(done), .rsp_id(rsp_id),
    .y(y), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    f0 = 3'd0; f1 = 3'd0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick(); tick();
    total++;
    if ({gnt0, gnt1, done, rsp_id, y, err, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt0=%b gnt1=%b done=%b id=%b y=%h err=%b busy=%b, want all 0",
               gnt0, gnt1, done, rsp_id, y, err, busy);
    end
    rst = 1'b0;
    tick(); tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_req: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_single_add();
    req0 = 1'b1; f0 = 3'd0; a0 = 32'd5; b0 = 32'd7;
    tick();
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL add_grant: got gnt0=%b gnt1=%b busy=%b done=%b, want 1 0 1 0", gnt0, gnt1, busy, done);
    end
    req0 = 1'b0;
    tick();
    total++;
    if (done !== 1'b1 || y !== 32'd12 || err !== 1'b0 || rsp_id !== 1'b0 || gnt0 !== 1'b0) begin
      bad++;
      $display("FAIL add_result: got done=%b y=%h err=%b id=%b gnt0=%b, want 1 0000000c 0 0 0",
               done, y, err, rsp_id, gnt0);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || y !== 32'd12) begin
      bad++;
      $display("FAIL add_idle: got done=%b busy=%b y=%h, want 0 0 0000000c", done, busy, y);
    end
  endtask

  task automatic test_alternation();
    logic [WIDTH-1:0] exp_y;
    logic             exp_id;
    rst = 1'b1;
    req0 = 1'b1; f0 = 3'd1; a0 = 32'd3;    b0 = 32'd5;
    req1 = 1'b1; f1 = 3'd4; a1 = 32'hF0;   b1 = 32'hFF;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_id = 1'(k % 2);
      exp_y  = exp_id ? 32'h0000_000F : 32'hFFFF_FFFE;
      tick();
      total++;
      if (gnt0 !== !exp_id || gnt1 !== exp_id) begin
        bad++;
        $display("FAIL alt_grant%0d: got gnt0=%b gnt1=%b, want %b %b", k, gnt0, gnt1, !exp_id, exp_id);
      end
      tick();
      total++;
      if (done !== 1'b1 || y !== exp_y || rsp_id !== exp_id || err !== 1'b0) begin
        bad++;
        $display("FAIL alt_result%0d: got done=%b y=%h id=%b err=%b, want 1 %h %b 0",
                 k, done, y, rsp_id, err, exp_y, exp_id);
      end
      tick();
      total++;
      if (done !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
        bad++;
        $display("FAIL alt_idle%0d: got done=%b gnt0=%b gnt1=%b, want 0 0 0", k, done, gnt0, gnt1);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_invalid_op();
    req1 = 1'b1; f1 = 3'd6; a1 = 32'h1234; b1 = 32'h55;
    tick();
    total++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      bad++;
      $display("FAIL inv_grant: got gnt0=%b gnt1=%b, want 0 1", gnt0, gnt1);
    end
    req1 = 1'b0;
    tick();
    total++;
    if (done !== 1'b1 || y !== 32'd0 || err !== 1'b1 || rsp_id !== 1'b1) begin
      bad++;
      $display("FAIL inv_result: got done=%b y=%h err=%b id=%b, want 1 00000000 1 1", done, y, err, rsp_id);
    end
    tick();
    total++;
    if (done !== 1'b0 || err !== 1'b1 || rsp_id !== 1'b1) begin
      bad++;
      $display("FAIL inv_hold: got done=%b err=%b id=%b, want 0 1 1", done, err, rsp_id);
    end
    req0 = 1'b1; f0 = 3'd2; a0 = 32'hFF00; b0 = 32'h0FF0;
    tick();
    req0 = 1'b0;
    tick();
    total++;
    if (done !== 1'b1 || y !== 32'h0F00 || err !== 1'b0 || rsp_id !== 1'b0) begin
      bad++;
      $display("FAIL and_clears_err: got done=%b y=%h err=%b id=%b, want 1 00000f00 0 0", done, y, err, rsp_id);
    end
    tick();
  endtask

  task automatic test_wrap_capture();
    req0 = 1'b1; f0 = 3'd0; a0 = 32'hFFFF_FFFF; b0 = 32'd1;
    tick();
    total++;
    if (gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL wrap_grant: got gnt0=%b, want 1", gnt0);
    end
    req0 = 1'b0; a0 = 32'd5; b0 = 32'd9;
    tick();
    total++;
    if (done !== 1'b1 || y !== 32'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL wrap_result: got done=%b y=%h err=%b, want 1 00000000 0", done, y, err);
    end
    tick();
  endtask

  task automatic test_reset_in_exec();
    req0 = 1'b1; f0 = 3'd0; a0 = 32'd1; b0 = 32'd1;
    tick();
    total++;
    if (gnt0 !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rx_grant: got gnt0=%b busy=%b, want 1 1", gnt0, busy);
    end
    req0 = 1'b0; rst = 1'b1;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || gnt0 !== 1'b0 || y !== 32'd0) begin
      bad++;
      $display("FAIL rx_flush: got done=%b busy=%b gnt0=%b y=%h, want 0 0 0 00000000", done, busy, gnt0, y);
    end
    rst = 1'b0;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rx_no_done: got done=%b busy=%b, want 0 0", done, busy);
    end
    req0 = 1'b1; f0 = 3'd0; a0 = 32'd2; b0 = 32'd2;
    req1 = 1'b1; f1 = 3'd1; a1 = 32'd9; b1 = 32'd4;
    tick();
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL rx_ptr: got gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    total++;
    if (done !== 1'b1 || y !== 32'd4 || rsp_id !== 1'b0) begin
      bad++;
      $display("FAIL rx_result: got done=%b y=%h id=%b, want 1 00000004 0", done, y, rsp_id);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_alternation();
    test_invalid_op();
    test_wrap_capture();
    test_reset_in_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
